lcv_dot_prod_seq: RTL and testbench
===================================

// Module: lcv_dot_prod_seq
// PURPOSE
//  Sequences one 16x16 signed multiply-accumulate datapath to compute a dot product over a streamed vector.
//  A command (length, bias) is accepted first, then cmd_len operand pairs, then one 33-bit signed result.
//  Sits between operand/result streams and the DSP-mapped MAC.
//  Gives client blocks a handshaked dot-product service without exposing MAC pipeline timing.
// PARAMETERS
//  DATA_W  16  operand width, signed
//  ACC_W   33  accumulator/result width, signed, two's complement; ACC_W >= 2*DATA_W
//  LEN_W   8   vector length field width; max vector = 2**LEN_W-1 pairs
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       asynchronous reset, active-high
//  cmd_valid  in   1       command present
//  cmd_ready  out  1       command accepted when cmd_valid&cmd_ready
//  cmd_len    in   LEN_W   number of operand pairs
//  cmd_bias   in   ACC_W   initial accumulator value
//  in_valid   in   1       operand pair present
//  in_ready   out  1       pair accepted when in_valid&in_ready
//  in_a       in   DATA_W  operand a, signed
//  in_b       in   DATA_W  operand b, signed
//  res_valid  out  1       result present
//  res_ready  in   1       result consumed when res_valid&res_ready
//  res_data   out  ACC_W   final accumulator
//  res_ovf    out  1       sticky signed overflow seen during this command
//  busy       out  1       state != IDLE
// BEHAVIOUR
//  Reset: state=IDLE. cmd_ready=1, in_ready=0, res_valid=0, res_data=0, res_ovf=0, busy=0.
//  Reset clears remaining count, accumulator and pipe valid.
//  Reset mid-operation discards the partial result; no res_valid is issued for that command.
//  States:
//   IDLE : cmd_ready=1. On cmd handshake: acc<=cmd_bias, rem<=cmd_len, ovf<=0.
//          Go to DONE if cmd_len==0, else go to RUN.
//   RUN  : in_ready=1 while rem!=0. Each pair handshake: rem<=rem-1, product issued to MAC stage.
//          When the pair with rem==1 is accepted, go to DRAIN.
//   DRAIN: in_ready=0. Wait until the MAC pipe valid is clear (one cycle after the last accept), then go to DONE.
//   DONE : res_valid=1; res_data/res_ovf held stable until res_ready. On handshake go to IDLE.
//  cmd_ready=1 only in IDLE, so a new command never overlaps a pending result.
//  Pipeline, two stages:
//   stage 1: registered product p = in_a*in_b (2*DATA_W bits, signed) plus pipe valid.
//   stage 2: acc <= acc + sext(p), wrapping at ACC_W.
//  Overflow: form the sum at ACC_W+1 bits. ovf |= (sum[ACC_W] != sum[ACC_W-1]). Flag is sticky per command.
//  Latency: res_valid rises 2 cycles after the last pair handshake.
//  Latency for cmd_len==0: res_valid rises 1 cycle after the cmd handshake, with res_data=cmd_bias.
//  Gaps on in_valid stall RUN without a timeout; the accumulator only updates for valid pipe entries.
//  res_ready held low keeps the block in DONE indefinitely.
//  Outputs are registered or decoded directly from state; there is no combinational path from any input to any output.
// STRUCTURE
//  Package lcv_mul_acc_pkg holds:
//   state encoding localparams (IDLE=0, RUN=1, DRAIN=2, DONE=3)
//   default DATA_W, ACC_W and LEN_W constants.
//  Sub-module lcv_mac_stage holds the registered multiply (DSP-mapped) plus its valid bit.
//  The top level holds the FSM, counter, accumulator and overflow logic.
// TESTING
//  1 len=3, bias=10, pairs (2,3),(4,5),(-1,7) -> res_data=29, ovf=0, res_valid 2 cycles after 3rd accept.
//  2 len=0, bias=-5 -> res_data=-5 one cycle after the cmd handshake; in_ready stays 0 throughout.
//  3 len=1, bias=2**32-1, pair (1,1) -> res_data=-2**32 (wrapped), res_ovf=1.
//  4 len=4, bias=0, four pairs (-32768,-32768) -> sum 2**32 wraps to -2**32, ovf=1.
//  5 len=2, in_valid gaps of 3 cycles and res_ready low for 5 cycles -> res_data held stable, cmd_ready=0.
//    Next cmd starts with ovf=0.
//  6 rst asserted in RUN after 1 of 3 pairs -> same cycle: res_valid=0, in_ready=0, busy=0.
//    Next len=1, bias=0, pair (3,3) -> res_data=9.

Source files
------------

// File: rtl/lcv_mul_acc_pkg.sv
// Package: lcv_mul_acc_pkg
// Purpose: shared constants and types for the dot-product sequencer.
//   - default operand, accumulator and length widths
//   - FSM state encoding (IDLE=0, RUN=1, DRAIN=2, DONE=3)
//   - helper for detecting signed overflow from a one-bit-extended sum
package lcv_mul_acc_pkg;

    localparam int LCV_DATA_W = 16;
    localparam int LCV_ACC_W  = 33;
    localparam int LCV_LEN_W  = 8;

    localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
    localparam logic [1:0] ST_RUN_ENC   = 2'd1;
    localparam logic [1:0] ST_DRAIN_ENC = 2'd2;
    localparam logic [1:0] ST_DONE_ENC  = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE_ENC,
        S_RUN   = ST_RUN_ENC,
        S_DRAIN = ST_DRAIN_ENC,
        S_DONE  = ST_DONE_ENC
    } state_t;

    // A sum formed one bit wider than its operands overflowed the narrower
    // format when its top two bits disagree.
    function automatic logic signed_ovf(input logic sum_ext_msb, input logic sum_msb);
        return sum_ext_msb ^ sum_msb;
    endfunction

endpackage

// File: rtl/lcv_mac_stage.sv
// Module: lcv_mac_stage
// Purpose: registered signed multiply (first MAC pipeline stage) plus its
//          valid bit. The product only updates when a pair is accepted.
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous reset, active-high
//   in_fire    in   operand pair accepted this cycle
//   in_a/in_b  in   signed operands
//   prod       out  registered signed product, 2*DATA_W bits
//   prod_valid out  prod holds a pair accepted on the previous cycle
module lcv_mac_stage
    import lcv_mul_acc_pkg::*;
#(
    parameter int DATA_W = LCV_DATA_W
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_fire,
    input  logic signed [DATA_W-1:0]   in_a,
    input  logic signed [DATA_W-1:0]   in_b,
    output logic signed [2*DATA_W-1:0] prod,
    output logic                       prod_valid
);

    // Product register and its valid flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod       <= {(2*DATA_W){1'b0}};
            prod_valid <= 1'b0;
        end else begin
            prod_valid <= in_fire;
            if (in_fire) begin
                prod <= in_a * in_b;
            end else begin
                prod <= prod;
            end
        end
    end

endmodule

// File: rtl/lcv_dot_prod_seq.sv
// Module: lcv_dot_prod_seq
// Purpose: sequences a two-stage signed MAC to compute bias + sum(a*b) over a
//          streamed vector. A command (len, bias) is accepted, then len operand
//          pairs, then one ACC_W-bit result with a sticky overflow flag.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   cmd_valid/cmd_ready           command handshake (ready only in IDLE)
//   cmd_len, cmd_bias             vector length and initial accumulator
//   in_valid/in_ready, in_a, in_b operand pair stream
//   res_valid/res_ready           result handshake
//   res_data, res_ovf             final accumulator and sticky overflow
//   busy                          sequencer not idle
// All outputs are registers or direct decodes of registered state.
module lcv_dot_prod_seq
    import lcv_mul_acc_pkg::*;
#(
    parameter int DATA_W = LCV_DATA_W,
    parameter int ACC_W  = LCV_ACC_W,
    parameter int LEN_W  = LCV_LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [ACC_W-1:0]  cmd_bias,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  res_data,
    output logic              res_ovf,
    output logic              busy
);

    state_t                      state;
    logic [LEN_W-1:0]            rem;
    logic [ACC_W-1:0]            acc;
    logic                        ovf;
    logic signed [2*DATA_W-1:0]  prod;
    logic                        prod_valid;
    logic                        in_fire;
    logic signed [ACC_W:0]       sum;

    // Output decodes from registered state.
    assign cmd_ready = (state == S_IDLE);
    assign in_ready  = (state == S_RUN) && (rem != {LEN_W{1'b0}});
    assign res_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);
    assign res_data  = acc;
    assign res_ovf   = ovf;

    assign in_fire = in_valid & in_ready;

    // Sum is formed one bit wider than the accumulator so wrap can be detected.
    assign sum = $signed({acc[ACC_W-1], acc}) + (ACC_W+1)'(prod);

    lcv_mac_stage #(
        .DATA_W (DATA_W)
    ) u_mac (
        .clk        (clk),
        .rst        (rst),
        .in_fire    (in_fire),
        .in_a       ($signed(in_a)),
        .in_b       ($signed(in_b)),
        .prod       (prod),
        .prod_valid (prod_valid)
    );

    // Sequencer FSM with remaining-pair counter, accumulator and sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            rem   <= {LEN_W{1'b0}};
            acc   <= {ACC_W{1'b0}};
            ovf   <= 1'b0;
        end else begin
            // Second MAC stage: only valid pipe entries touch the accumulator.
            if (prod_valid) begin
                acc <= sum[ACC_W-1:0];
                if (signed_ovf(sum[ACC_W], sum[ACC_W-1])) begin
                    ovf <= 1'b1;
                end else begin
                    ovf <= ovf;
                end
            end else begin
                acc <= acc;
            end

            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        acc <= cmd_bias;
                        rem <= cmd_len;
                        ovf <= 1'b0;
                        if (cmd_len == {LEN_W{1'b0}}) begin
                            state <= S_DONE;
                        end else begin
                            state <= S_RUN;
                        end
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_RUN: begin
                    if (in_fire) begin
                        rem <= rem - LEN_W'(1);
                        if (rem == LEN_W'(1)) begin
                            state <= S_DRAIN;
                        end else begin
                            state <= S_RUN;
                        end
                    end else begin
                        state <= S_RUN;
                    end
                end
                S_DRAIN: begin
                    // The last product lands in acc on the cycle its valid clears.
                    if (!prod_valid) begin
                        state <= S_DONE;
                    end else begin
                        state <= S_DRAIN;
                    end
                end
                S_DONE: begin
                    if (res_ready) begin
                        state <= S_IDLE;
                    end else begin
                        state <= S_DONE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcv_dot_prod_seq.sv
module tb_lcv_dot_prod_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_len;
    logic [32:0] cmd_bias;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        res_valid;
    logic        res_ready;
    logic [32:0] res_data;
    logic        res_ovf;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic signed [15:0] qa[$];
    logic signed [15:0] qb[$];

    always #5 clk = ~clk;

    lcv_dot_prod_seq dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_len   (cmd_len),
        .cmd_bias  (cmd_bias),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_ovf   (res_ovf),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: bias + sum of products, wrapping at 33 bits; overflow if any
    // partial sum leaves the signed 33-bit range.
    task automatic model(input logic [32:0] bias, input int len,
                         output logic [32:0] exp_res, output logic exp_ovf);
        longint acc;
        longint t;
        logic [63:0] tv;
        logic [32:0] w;
        acc = longint'($signed(bias));
        exp_ovf = 1'b0;
        for (int i = 0; i < len; i++) begin
            t = acc + longint'(qa[i]) * longint'(qb[i]);
            if (t > 64'sd4294967295 || t < -64'sd4294967296) exp_ovf = 1'b1;
            tv = t;
            w = tv[32:0];
            acc = longint'($signed(w));
        end
        tv = acc;
        exp_res = tv[32:0];
    endtask

    task automatic send_cmd(input int len, input logic [32:0] bias);
        int k;
        cmd_len   = 8'(len);
        cmd_bias  = bias;
        cmd_valid = 1'b1;
        k = 0;
        while (!cmd_ready && k < 200) begin
            step();
            k++;
        end
        if (!cmd_ready) check("cmd_ready_timeout", 64'(cmd_ready), 64'd1);
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic send_pair(input logic [15:0] a, input logic [15:0] b);
        int k;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 200) begin
            step();
            k++;
        end
        if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
    endtask

    // One full command using qa/qb, with in_valid gaps and res_ready hold-off.
    task automatic do_cmd(input string tag, input int len, input logic [32:0] bias,
                          input int gap, input int hold);
        logic [32:0] exp_res;
        logic        exp_ovf;
        model(bias, len, exp_res, exp_ovf);
        send_cmd(len, bias);
        if (len == 0) begin
            check({tag, "_in_ready_len0"}, 64'(in_ready), 64'd0);
        end else begin
            for (int i = 0; i < len; i++) begin
                for (int g = 0; g < gap; g++) begin
                    step();
                    check({tag, "_gap_cmd_ready"}, 64'(cmd_ready), 64'd0);
                end
                send_pair(qa[i], qb[i]);
            end
            check({tag, "_lat0_valid"}, 64'(res_valid), 64'd0);
            check({tag, "_lat0_in_ready"}, 64'(in_ready), 64'd0);
            step();
            check({tag, "_lat1_valid"}, 64'(res_valid), 64'd0);
            step();
        end
        check({tag, "_res_valid"}, 64'(res_valid), 64'd1);
        for (int h = 0; h < hold; h++) begin
            step();
            check({tag, "_hold_valid"}, 64'(res_valid), 64'd1);
            check({tag, "_hold_data"}, 64'(res_data), 64'(exp_res));
            check({tag, "_hold_cmd_ready"}, 64'(cmd_ready), 64'd0);
        end
        check({tag, "_res_data"}, 64'(res_data), 64'(exp_res));
        check({tag, "_res_ovf"}, 64'(res_ovf), 64'(exp_ovf));
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check({tag, "_after_valid"}, 64'(res_valid), 64'd0);
        check({tag, "_after_busy"}, 64'(busy), 64'd0);
        check({tag, "_after_cmd_ready"}, 64'(cmd_ready), 64'd1);
    endtask

    initial begin
        logic [32:0] rb;
        int rl;
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_len = 8'd0;
        cmd_bias = 33'd0;
        in_valid = 1'b0;
        in_a = 16'd0;
        in_b = 16'd0;
        res_ready = 1'b0;
        #1;
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_res_valid", 64'(res_valid), 64'd0);
        check("rst_res_data", 64'(res_data), 64'd0);
        check("rst_res_ovf", 64'(res_ovf), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        step();
        step();
        rst = 1'b0;
        step();

        // 1: basic dot product
        qa = '{16'sd2, 16'sd4, -16'sd1};
        qb = '{16'sd3, 16'sd5, 16'sd7};
        do_cmd("t1", 3, 33'd10, 0, 0);
        check("t1_model_sanity_data", 64'(res_data), 64'd29);

        // 2: zero length returns bias one cycle after the command
        qa = {};
        qb = {};
        do_cmd("t2", 0, -33'sd5, 0, 0);

        // 3: max positive bias plus one wraps negative
        qa = '{16'sd1};
        qb = '{16'sd1};
        do_cmd("t3", 1, 33'h0_FFFF_FFFF, 0, 0);

        // 4: four max-magnitude products reach 2**32
        qa = '{-16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768};
        qb = '{-16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768};
        do_cmd("t4", 4, 33'd0, 0, 0);

        // 5: input gaps and result back-pressure; overflow flag starts clear
        qa = '{16'sd100, -16'sd7};
        qb = '{16'sd200, 16'sd9};
        do_cmd("t5", 2, 33'd1, 3, 5);

        // 6: reset in RUN after one of three pairs
        send_cmd(3, 33'd50);
        send_pair(16'd5, 16'd5);
        check("t6_busy_before", 64'(busy), 64'd1);
        check("t6_in_ready_before", 64'(in_ready), 64'd1);
        rst = 1'b1;
        #1;
        check("t6_rst_res_valid", 64'(res_valid), 64'd0);
        check("t6_rst_in_ready", 64'(in_ready), 64'd0);
        check("t6_rst_busy", 64'(busy), 64'd0);
        #2;
        rst = 1'b0;
        step();
        check("t6_post_rst_valid", 64'(res_valid), 64'd0);
        qa = '{16'sd3};
        qb = '{16'sd3};
        do_cmd("t6b", 1, 33'd0, 0, 0);

        // Randomized commands against the reference model
        for (int r = 0; r < 8; r++) begin
            rl = $urandom_range(1, 9);
            qa = {};
            qb = {};
            for (int i = 0; i < rl; i++) begin
                qa.push_back(16'($urandom()));
                qb.push_back(16'($urandom()));
            end
            rb[31:0] = $urandom();
            rb[32]   = 1'($urandom_range(0, 1));
            do_cmd("rnd", rl, rb, $urandom_range(0, 2), $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
